leg_branch_sequencer: RTL and testbench
=======================================

Name: leg_branch_sequencer

Overview:
Program-counter sequencer for the LEG core. It advances the PC on ordinary instruction steps and handles conditional branches. For a branch it drives the 8-bit condition-unit datapath (OP1/OP2/OP), waits a fixed evaluation latency, samples the 1-bit condition result, and commits either the branch target or PC+step. It emits a one-cycle flush on taken branches and keeps a saturating taken-branch counter.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
PC_STEP, 8'd4, PC increment for a non-taken or non-branch step; addition modulo 256
COND_LAT, 1, cycles between driving cond_op* and sampling cond_result; legal range 1..3

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
step_valid  input  1  requester presents an instruction step
step_ready  output  1  sequencer accepts a step; a transfer occurs when step_valid && step_ready
is_branch  input  1  step is a conditional branch
br_op  input  8  condition opcode, passed to the condition unit unchanged (low nibble: 0 EQ, 1 NE, 2 LTU, 3 LEU, 4 GTU, 5 GEU, 6 always, 7..F never)
br_a  input  8  first comparison operand
br_b  input  8  second comparison operand
br_target  input  8  branch destination
cond_op1  output  8  to condition unit OP1
cond_op2  output  8  to condition unit OP2
cond_op  output  8  to condition unit OP
cond_result  input  1  condition unit Output
pc  output  8  current program counter
flush  output  1  one-cycle pulse after a taken branch commits
busy  output  1  high while a branch is evaluating
taken_count  output  8  saturating count of taken branches

Behaviour:
- Reset (rst=0, asynchronous) sets: pc=RESET_PC, state=IDLE, step_ready=1, busy=0, flush=0, cond_op1/cond_op2/cond_op=0, taken_count=0, wait counter=0.
- Reset deasserted: normal operation starts at the first rising edge of clk after deassertion.
- States:
  - IDLE: step_ready = !flush.
  - EVAL: step_ready=0, busy=1.
- Non-branch transfer in IDLE: pc <= pc+PC_STEP at the same edge. State stays IDLE, giving one step per cycle. Wrap-around: 8'hFC+4 = 8'h00.
- Branch transfer in IDLE:
  - register br_a, br_b and br_op into cond_op1, cond_op2 and cond_op;
  - register br_target internally;
  - load the wait counter with COND_LAT; state becomes EVAL.
- cond_op* hold their values until the next branch transfer. They are not cleared on return to IDLE.
- EVAL: the wait counter decrements each edge. On the edge where the counter equals 1:
  - cond_result sampled 1: pc <= target, flush <= 1, taken_count <= taken_count+1, saturating at 8'hFF.
  - cond_result sampled 0: pc <= pc+PC_STEP, flush <= 0.
  - State becomes IDLE in both cases.
- Branch latency: the new pc is visible COND_LAT+1 cycles after the transfer cycle. The bench's condition-unit model presents cond_result combinationally from cond_op*, delayed by COND_LAT-1 cycles.
- flush is high for exactly one cycle, the first IDLE cycle after a taken commit. step_ready=0 in that cycle (wrong-path bubble), so no step transfers then.
- step_valid while step_ready=0 is ignored. No input is sampled, and the requester holds its request.
- busy = (state==EVAL).
- Reset asserted in mid-EVAL abandons the branch: no commit and no flush pulse. All outputs take their reset values immediately.
- Opcodes with low nibble 7..F are forwarded unchanged. The commit follows cond_result only; the sequencer does not decode the condition.
- All outputs are driven from registers, except step_ready and busy, which are decoded from state and flush.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> pc=8'h00, step_ready=1, busy=0, flush=0, taken_count=0, cond_op*=0. Release, then hold step_valid=0 -> pc stays 8'h00.
- Sequential: step_valid=1, is_branch=0 for 3 cycles from pc=0 -> pc reads 4, 8, 12 on consecutive cycles; busy stays 0.
- Wrap-around: drive pc to 8'hFC, apply one non-branch step -> pc=8'h00.
- Taken branch (COND_LAT=1): at pc=8'h08, branch with br_op=8'h00 (EQ), a=5, b=5, target=8'h40.
  - Next cycle: cond_op1=5, cond_op2=5, cond_op=0, busy=1, step_ready=0.
  - Following cycle: pc=8'h40, flush=1, step_ready=0, taken_count=1.
  - One cycle after that: flush=0, step_ready=1.
- Not-taken branch (COND_LAT=1): at pc=8'h10, br_op=8'h02 (LTU), a=9, b=3, target=8'h80 -> pc=8'h14, flush never asserts, taken_count unchanged.
- Reset mid-EVAL and saturation: with COND_LAT=3, assert rst=0 in the second EVAL cycle -> pc=RESET_PC, busy=0, no flush pulse. Separately, apply 260 taken branches with br_op=8'h06 -> taken_count=8'hFF.

Source files
------------

// File: rtl/leg_branch_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : leg_branch_sequencer_if
//  Brief    : Step request bus plus condition-unit datapath of the LEG sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface leg_branch_sequencer_if;
    logic       step_valid;
    logic       step_ready;
    logic       is_branch;
    logic [7:0] br_op;
    logic [7:0] br_a;
    logic [7:0] br_b;
    logic [7:0] br_target;
    logic [7:0] cond_op1;
    logic [7:0] cond_op2;
    logic [7:0] cond_op;
    logic       cond_result;

    // Requester and condition unit together form the master side
    modport master (
        output step_valid, is_branch, br_op, br_a, br_b, br_target, cond_result,
        input  step_ready, cond_op1, cond_op2, cond_op
    );

    modport slave (
        input  step_valid, is_branch, br_op, br_a, br_b, br_target, cond_result,
        output step_ready, cond_op1, cond_op2, cond_op
    );
endinterface
`default_nettype wire

// File: rtl/leg_branch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : leg_branch_sequencer
//  Brief    : LEG program-counter sequencer with conditional branch resolution
//  Revision : 1.0  initial release
// ============================================================================
module leg_branch_sequencer #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [7:0]  PC_STEP  = 8'd4,
    parameter int unsigned COND_LAT = 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    leg_branch_sequencer_if.slave       bus,
    output      logic [7:0]             pc,
    output      logic                   flush,
    output      logic                   busy,
    output      logic [7:0]             taken_count
);

    localparam logic [1:0] c_cond_lat = 2'(COND_LAT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EVAL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pc,     w_pc_next;
    logic [7:0] r_target, w_target_next;
    logic [7:0] r_op1,    w_op1_next;
    logic [7:0] r_op2,    w_op2_next;
    logic [7:0] r_op,     w_op_next;
    logic [7:0] r_taken,  w_taken_next;
    logic [1:0] r_wait,   w_wait_next;
    logic       r_flush,  w_flush_next;
    logic       w_step_ready;
    logic       w_xfer;

    // The cycle right after a taken commit is a wrong-path bubble
    assign w_step_ready = (r_state == S_IDLE) && !r_flush;
    assign w_xfer       = bus.step_valid && w_step_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_target <= 8'h00;
            r_op1    <= 8'h00;
            r_op2    <= 8'h00;
            r_op     <= 8'h00;
            r_taken  <= 8'h00;
            r_wait   <= 2'd0;
            r_flush  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_target <= w_target_next;
            r_op1    <= w_op1_next;
            r_op2    <= w_op2_next;
            r_op     <= w_op_next;
            r_taken  <= w_taken_next;
            r_wait   <= w_wait_next;
            r_flush  <= w_flush_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_op1_next    = r_op1;
        w_op2_next    = r_op2;
        w_op_next     = r_op;
        w_taken_next  = r_taken;
        w_wait_next   = r_wait;
        w_flush_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (bus.is_branch) begin
                        w_op1_next    = bus.br_a;
                        w_op2_next    = bus.br_b;
                        w_op_next     = bus.br_op;
                        w_target_next = bus.br_target;
                        w_wait_next   = c_cond_lat;
                        w_state_next  = S_EVAL;
                    end else begin
                        w_pc_next = r_pc + PC_STEP;
                    end
                end
            end
            S_EVAL: begin
                w_wait_next = r_wait - 2'd1;
                if (r_wait == 2'd1) begin
                    w_state_next = S_IDLE;
                    if (bus.cond_result) begin
                        w_pc_next    = r_target;
                        w_flush_next = 1'b1;
                        w_taken_next = (r_taken == 8'hFF) ? r_taken : r_taken + 8'd1;
                    end else begin
                        w_pc_next = r_pc + PC_STEP;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.step_ready = w_step_ready;
    assign bus.cond_op1   = r_op1;
    assign bus.cond_op2   = r_op2;
    assign bus.cond_op    = r_op;
    assign pc             = r_pc;
    assign flush          = r_flush;
    assign busy           = (r_state == S_EVAL);
    assign taken_count    = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_leg_branch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_leg_branch_sequencer
//  Brief    : Self-checking bench, COND_LAT=1 and COND_LAT=3 instances
//  Revision : 1.0  initial release
// ============================================================================
module tb_leg_branch_sequencer;

    localparam logic [7:0] c_reset_pc = 8'h00;
    localparam logic [7:0] c_step     = 8'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   phase = 1'b0;     // 0 drives the COND_LAT=1 instance, 1 the COND_LAT=3 one
    bit   chk_on = 1'b0;

    logic       s_valid = 1'b0, s_isbr = 1'b0;
    logic [7:0] s_op = 8'h00, s_a = 8'h00, s_b = 8'h00, s_tgt = 8'h00;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Condition unit: plain unsigned compare decoded from the low nibble
    function automatic logic cond_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op[3:0])
            4'h0:    return a == b;
            4'h1:    return a != b;
            4'h2:    return a <  b;
            4'h3:    return a <= b;
            4'h4:    return a >  b;
            4'h5:    return a >= b;
            4'h6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    leg_branch_sequencer_if if1 ();
    leg_branch_sequencer_if if3 ();
    logic [7:0] pc1, tc1, pc3, tc3;
    logic       fl1, bz1, fl3, bz3;
    logic [1:0] c3_pipe;

    assign if1.step_valid = s_valid & ~phase;
    assign if3.step_valid = s_valid &  phase;
    assign if1.is_branch  = s_isbr;  assign if3.is_branch = s_isbr;
    assign if1.br_op      = s_op;    assign if3.br_op     = s_op;
    assign if1.br_a       = s_a;     assign if3.br_a      = s_a;
    assign if1.br_b       = s_b;     assign if3.br_b      = s_b;
    assign if1.br_target  = s_tgt;   assign if3.br_target = s_tgt;
    assign if1.cond_result = cond_fn(if1.cond_op, if1.cond_op1, if1.cond_op2);
    assign if3.cond_result = c3_pipe[1];

    always @(posedge clk) begin
        c3_pipe[0] <= cond_fn(if3.cond_op, if3.cond_op1, if3.cond_op2);
        c3_pipe[1] <= c3_pipe[0];
    end

    leg_branch_sequencer #(.RESET_PC(c_reset_pc), .PC_STEP(c_step), .COND_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .pc(pc1), .flush(fl1), .busy(bz1), .taken_count(tc1));

    leg_branch_sequencer #(.RESET_PC(c_reset_pc), .PC_STEP(c_step), .COND_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave),
        .pc(pc3), .flush(fl3), .busy(bz3), .taken_count(tc3));

    logic [7:0] d_pc, d_tc, d_op1, d_op2, d_op;
    logic       d_fl, d_bz, d_rdy;
    assign d_pc  = phase ? pc3 : pc1;
    assign d_tc  = phase ? tc3 : tc1;
    assign d_fl  = phase ? fl3 : fl1;
    assign d_bz  = phase ? bz3 : bz1;
    assign d_rdy = phase ? if3.step_ready : if1.step_ready;
    assign d_op1 = phase ? if3.cond_op1 : if1.cond_op1;
    assign d_op2 = phase ? if3.cond_op2 : if1.cond_op2;
    assign d_op  = phase ? if3.cond_op  : if1.cond_op;

    // Behavioural model: a branch resolves a fixed number of edges after it is accepted
    int         cyc = 0;
    int         m_resolve_at = 0;
    bit         m_pending = 1'b0, m_out = 1'b0, m_flush = 1'b0;
    logic [7:0] m_pc = c_reset_pc, m_taken = 8'h00, m_tgt = 8'h00;
    logic [7:0] m_op1 = 8'h00, m_op2 = 8'h00, m_op = 8'h00;

    function automatic bit m_ready();
        return !m_pending && !m_flush;
    endfunction

    task automatic model_reset();
        m_pending = 1'b0; m_flush = 1'b0; m_out = 1'b0;
        m_pc = c_reset_pc; m_taken = 8'h00; m_tgt = 8'h00;
        m_op1 = 8'h00; m_op2 = 8'h00; m_op = 8'h00;
    endtask

    task automatic model_edge();
        bit accept;
        cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        accept  = s_valid && m_ready();
        m_flush = 1'b0;
        if (m_pending && cyc == m_resolve_at) begin
            m_pending = 1'b0;
            if (m_out) begin
                m_pc    = m_tgt;
                m_flush = 1'b1;
                if (m_taken != 8'hFF) m_taken = m_taken + 8'd1;
            end else begin
                m_pc = m_pc + c_step;
            end
        end else if (accept) begin
            if (s_isbr) begin
                m_op1 = s_a; m_op2 = s_b; m_op = s_op; m_tgt = s_tgt;
                m_out = cond_fn(s_op, s_a, s_b);
                m_pending = 1'b1;
                m_resolve_at = cyc + (phase ? 3 : 1);
            end else begin
                m_pc = m_pc + c_step;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc",          d_pc,  m_pc);
            chk("taken_count", d_tc,  m_taken);
            chk("flush",       {7'd0, d_fl},  {7'd0, m_flush});
            chk("busy",        {7'd0, d_bz},  {7'd0, m_pending});
            chk("step_ready",  {7'd0, d_rdy}, {7'd0, m_ready()});
            chk("cond_op1",    d_op1, m_op1);
            chk("cond_op2",    d_op2, m_op2);
            chk("cond_op",     d_op,  m_op);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
    endtask

    // Present one step and hold it until it is accepted
    task automatic xfer(input logic br, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] tgt);
        int n = 0;
        s_valid = 1'b1; s_isbr = br; s_op = op; s_a = a; s_b = b; s_tgt = tgt;
        while (!m_ready() && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("xfer_timeout", 8'd1, 8'd0);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] op;
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0; s_a = 8'($urandom);
                tick();
            end
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                              : {4'($urandom), 4'($urandom_range(0, 8))};
            xfer(($urandom_range(0, 2) == 0), op, 8'($urandom_range(0, 7)),
                 8'($urandom_range(0, 7)), 8'($urandom));
        end
        repeat (6) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        model_reset();
        #1;
        chk_on = 1'b1;
        do_reset();
        chk("rst_pc", d_pc, 8'h00);
        chk("rst_ready", {7'd0, d_rdy}, 8'd1);
        chk("rst_taken", d_tc, 8'h00);
        repeat (2) tick();
        chk("idle_pc", d_pc, 8'h00);

        for (int i = 1; i <= 3; i++) begin
            xfer(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
            chk("seq_pc", d_pc, 8'(4 * i));
        end

        do_reset();
        repeat (2) xfer(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("pre_br_pc", d_pc, 8'h08);
        xfer(1'b1, 8'h00, 8'd5, 8'd5, 8'h40);
        chk("tk_op1", d_op1, 8'd5);
        chk("tk_busy", {7'd0, d_bz}, 8'd1);
        chk("tk_ready0", {7'd0, d_rdy}, 8'd0);
        tick();
        chk("tk_pc", d_pc, 8'h40);
        chk("tk_flush", {7'd0, d_fl}, 8'd1);
        chk("tk_count", d_tc, 8'd1);
        tick();
        chk("tk_flush_end", {7'd0, d_fl}, 8'd0);
        chk("tk_ready1", {7'd0, d_rdy}, 8'd1);

        do_reset();
        repeat (4) xfer(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        xfer(1'b1, 8'h02, 8'd9, 8'd3, 8'h80);
        tick();
        chk("nt_pc", d_pc, 8'h14);
        chk("nt_count", d_tc, 8'd0);
        repeat (58) xfer(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("pre_wrap_pc", d_pc, 8'hFC);
        xfer(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("wrap_pc", d_pc, 8'h00);

        do_reset();
        repeat (260) xfer(1'b1, 8'h06, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (2) tick();
        chk("sat_count", d_tc, 8'hFF);

        run_random(300);

        phase = 1'b1;
        do_reset();
        xfer(1'b1, 8'h06, 8'h01, 8'h02, 8'h55);
        tick();
        chk("mid_busy_pre", {7'd0, d_bz}, 8'd1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_pc", d_pc, c_reset_pc);
        chk("mid_rst_busy", {7'd0, d_bz}, 8'd0);
        chk("mid_rst_flush", {7'd0, d_fl}, 8'd0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_flush", {7'd0, d_fl}, 8'd0);
            chk("mid_pc_hold", d_pc, c_reset_pc);
        end

        run_random(300);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
